// File: rtl/i2c_fifo_tx_master.sv
// I2C write-only master: sends START, 7-bit address + W, then len bytes popped
// from an upstream synchronous FIFO, checking ACK after each byte, then STOP.
module i2c_fifo_tx_master #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] slave_addr,
  input  logic [7:0] len,
  output logic       fifo_rd_en,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_i,
  output logic       busy,
  output logic       done,
  output logic       nack_err,
  output logic       underrun,
  output logic [7:0] bytes_sent
);

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    FETCH,
    WAIT_DATA,
    DATA,
    DATA_ACK,
    STOP
  } state_t;

  localparam logic [9:0] QMAX = 10'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [9:0]  qcnt_q, qcnt_d;
  logic [1:0]  phase_q, phase_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  bytes_q, bytes_d;
  logic        nack_q, nack_d;
  logic        nack_pend_q, nack_pend_d;
  logic        under_pend_q, under_pend_d;
  logic        done_q, done_d;
  logic        nack_err_q, nack_err_d;
  logic        underrun_q, underrun_d;

  logic        timed;
  logic        q_tick;
  logic        q_last;
  logic        ack_sample;
  logic [8:0]  bytes_inc;

  // FETCH and WAIT_DATA are untimed: SCL stays low until the next byte is in hand.
  assign timed      = !(state_q inside {IDLE, FETCH, WAIT_DATA});
  assign q_tick     = (qcnt_q == QMAX);
  assign q_last     = q_tick && (phase_q == 2'd3);
  assign ack_sample = (phase_q == 2'd3) && (qcnt_q == 10'd0);
  assign bytes_inc  = {1'b0, bytes_q} + 9'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      qcnt_q       <= '0;
      phase_q      <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      len_q        <= '0;
      bytes_q      <= '0;
      nack_q       <= 1'b0;
      nack_pend_q  <= 1'b0;
      under_pend_q <= 1'b0;
      done_q       <= 1'b0;
      nack_err_q   <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      qcnt_q       <= qcnt_d;
      phase_q      <= phase_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      len_q        <= len_d;
      bytes_q      <= bytes_d;
      nack_q       <= nack_d;
      nack_pend_q  <= nack_pend_d;
      under_pend_q <= under_pend_d;
      done_q       <= done_d;
      nack_err_q   <= nack_err_d;
      underrun_q   <= underrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    qcnt_d       = qcnt_q;
    phase_d      = phase_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    len_d        = len_q;
    bytes_d      = bytes_q;
    nack_d       = nack_q;
    nack_pend_d  = nack_pend_q;
    under_pend_d = under_pend_q;
    done_d       = 1'b0;
    nack_err_d   = 1'b0;
    underrun_d   = 1'b0;

    if (!timed) begin
      qcnt_d  = '0;
      phase_d = '0;
    end else if (q_tick) begin
      qcnt_d  = '0;
      phase_d = phase_q + 2'd1;
    end else begin
      qcnt_d  = qcnt_q + 10'd1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = START;
          shift_d      = {slave_addr, 1'b0};
          len_d        = len;
          bytes_d      = '0;
          nack_pend_d  = 1'b0;
          under_pend_d = 1'b0;
        end
      end
      START: begin
        if (q_last) begin
          state_d   = ADDR;
          bit_cnt_d = '0;
        end
      end
      ADDR, DATA: begin
        if (q_last) begin
          if (bit_cnt_q == 3'd7) begin
            state_d = (state_q == ADDR) ? ADDR_ACK : DATA_ACK;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {shift_q[6:0], 1'b0};
          end
        end
      end
      ADDR_ACK, DATA_ACK: begin
        if (ack_sample) begin
          nack_d = sda_i;
        end
        if (q_last) begin
          if (nack_q) begin
            nack_pend_d = 1'b1;
            state_d     = STOP;
          end else if (state_q == ADDR_ACK) begin
            state_d = (len_q == 8'd0) ? STOP : FETCH;
          end else begin
            bytes_d = bytes_q + 8'd1;
            state_d = (bytes_inc < {1'b0, len_q}) ? FETCH : STOP;
          end
        end
      end
      FETCH: begin
        if (fifo_empty) begin
          under_pend_d = 1'b1;
          state_d      = STOP;
        end else begin
          state_d = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        shift_d   = fifo_data;
        bit_cnt_d = '0;
        state_d   = DATA;
      end
      STOP: begin
        if (q_last) begin
          state_d    = IDLE;
          done_d     = 1'b1;
          nack_err_d = nack_pend_q;
          underrun_d = under_pend_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line drive: SCL low in q0-q1 of every bit, SDA only ever changes while SCL is low
  // except for the START and STOP conditions.
  always_comb begin
    scl_oe     = 1'b0;
    sda_oe     = 1'b0;
    fifo_rd_en = 1'b0;
    case (state_q)
      START: begin
        sda_oe = phase_q[1];
      end
      ADDR, DATA: begin
        scl_oe = ~phase_q[1];
        sda_oe = ~shift_q[7];
      end
      ADDR_ACK, DATA_ACK: begin
        scl_oe = ~phase_q[1];
      end
      FETCH: begin
        scl_oe     = 1'b1;
        fifo_rd_en = ~fifo_empty;
      end
      WAIT_DATA: begin
        scl_oe = 1'b1;
      end
      STOP: begin
        scl_oe = (phase_q == 2'd0);
        sda_oe = (phase_q != 2'd3);
      end
      default: begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
      end
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign nack_err   = nack_err_q;
  assign underrun   = underrun_q;
  assign bytes_sent = bytes_q;

endmodule

// File: tb/tb_i2c_fifo_tx_master.sv
// Directed bench: bus monitor + ACK-driving slave + FIFO model around the I2C write master.
module tb_i2c_fifo_tx_master;
  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [6:0] slave_addr = '0;
  logic [7:0] len = '0;
  logic       fifo_rd_en;
  logic [7:0] fifo_data = '0;
  logic       fifo_empty;
  logic       scl_oe, sda_oe, sda_i;
  logic       busy, done, nack_err, underrun;
  logic [7:0] bytes_sent;

  int total = 0;
  int bad = 0;

  i2c_fifo_tx_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .slave_addr(slave_addr), .len(len),
    .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_i(sda_i), .busy(busy), .done(done),
    .nack_err(nack_err), .underrun(underrun), .bytes_sent(bytes_sent)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears the cycle after a pop.
  logic [7:0] fifo_mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pops = 0;
  int bad_pops = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (rd_ptr == wr_ptr) bad_pops <= bad_pops + 1;
      else begin
        fifo_data <= fifo_mem[rd_ptr % 64];
        rd_ptr    <= rd_ptr + 1;
      end
      pops <= pops + 1;
    end
  end

  // Bus monitor and slave: pulls SDA for the ACK slot unless told to NACK that byte.
  logic       pull = 1'b0;
  logic [7:0] nack_plan = '0;
  logic [7:0] mon_bytes [0:7];
  logic       mon_acks  [0:7];
  logic [7:0] exp_bytes [0:7];
  logic       exp_acks  [0:7];
  int         nbytes = 0;
  int         bitcnt = 0;
  int         stop_cnt = 0;
  logic [7:0] sr = '0;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       scl_l, sda_l;

  assign sda_i = ~(sda_oe | pull);

  always @(negedge clk) begin
    scl_l = ~scl_oe;
    sda_l = sda_i;
    if (scl_l && prev_scl && prev_sda && !sda_l) begin
      bitcnt = 0;
      nbytes = 0;
      pull   = 1'b0;
    end
    if (scl_l && prev_scl && !prev_sda && sda_l) stop_cnt++;
    if (!prev_scl && scl_l && nbytes < 8) begin
      if (bitcnt < 8) begin
        sr = {sr[6:0], sda_l};
        bitcnt++;
        if (bitcnt == 8) mon_bytes[nbytes] = sr;
      end else if (bitcnt == 8) begin
        mon_acks[nbytes] = sda_l;
        bitcnt = 9;
      end
    end
    if (prev_scl && !scl_l) begin
      if (bitcnt == 8) pull = ~nack_plan[nbytes % 8];
      else if (bitcnt == 9) begin
        pull   = 1'b0;
        bitcnt = 0;
        nbytes++;
      end
    end
    prev_scl = scl_l;
    prev_sda = sda_l;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr % 64] = b;
    wr_ptr++;
  endtask

  int pops0 = 0;
  int stops0 = 0;

  task automatic begin_txn(input logic [6:0] a, input logic [7:0] l);
    @(negedge clk);
    slave_addr = a;
    len        = l;
    start      = 1'b1;
    pops0      = pops;
    stops0     = stop_cnt;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic end_txn(input string name, input int exp_n, input int exp_pops,
                         input int exp_sent, input int exp_nack, input int exp_ur);
    bit   seen = 1'b0;
    logic ne = 1'b0;
    logic ur = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        ne   = nack_err;
        ur   = underrun;
      end
    end
    chk({name, "_done"}, seen, 1);
    chk({name, "_nack_err"}, ne, exp_nack);
    chk({name, "_underrun"}, ur, exp_ur);
    chk({name, "_bytes_sent"}, bytes_sent, exp_sent);
    chk({name, "_pops"}, pops - pops0, exp_pops);
    chk({name, "_nbytes"}, nbytes, exp_n);
    chk({name, "_stops"}, stop_cnt - stops0, 1);
    for (int i = 0; i < exp_n; i++) begin
      chk($sformatf("%s_byte%0d", name, i), mon_bytes[i], exp_bytes[i]);
      chk($sformatf("%s_ack%0d", name, i), mon_acks[i], exp_acks[i]);
    end
    @(negedge clk);
    chk({name, "_done_one_cycle"}, done, 0);
    chk({name, "_idle_busy"}, busy, 0);
    chk({name, "_bytes_held"}, bytes_sent, exp_sent);
    chk({name, "_no_empty_pop"}, bad_pops, 0);
    $display("txn %s: bytes_on_bus=%0d pops=%0d bytes_sent=%0d nack_err=%0b underrun=%0b",
             name, nbytes, pops - pops0, bytes_sent, ne, ur);
  endtask

  initial begin
    bit hit;
    repeat (3) @(negedge clk);
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_nack_err", nack_err, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_bytes_sent", bytes_sent, 0);
    chk("rst_fifo_rd_en", fifo_rd_en, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two bytes, all ACKed
    nack_plan = 8'h00;
    push(8'hA5); push(8'h3C);
    exp_bytes[0] = 8'hA0; exp_bytes[1] = 8'hA5; exp_bytes[2] = 8'h3C;
    exp_acks[0] = 0; exp_acks[1] = 0; exp_acks[2] = 0;
    begin_txn(7'h50, 8'd2);
    end_txn("basic", 3, 2, 2, 0, 0);

    // Address NACK
    nack_plan = 8'h01;
    push(8'h77);
    exp_bytes[0] = 8'h42; exp_acks[0] = 1;
    begin_txn(7'h21, 8'd3);
    end_txn("addr_nack", 1, 0, 0, 1, 0);
    wr_ptr = rd_ptr;

    // FIFO runs dry after two of four bytes
    nack_plan = 8'h00;
    push(8'h11); push(8'h22);
    exp_bytes[0] = 8'hA0; exp_bytes[1] = 8'h11; exp_bytes[2] = 8'h22;
    exp_acks[0] = 0; exp_acks[1] = 0; exp_acks[2] = 0;
    begin_txn(7'h50, 8'd4);
    end_txn("underrun", 3, 2, 2, 0, 1);

    // Second data byte NACKed
    nack_plan = 8'h04;
    push(8'h81); push(8'h7E); push(8'h99);
    exp_bytes[0] = 8'h74; exp_bytes[1] = 8'h81; exp_bytes[2] = 8'h7E;
    exp_acks[0] = 0; exp_acks[1] = 0; exp_acks[2] = 1;
    begin_txn(7'h3A, 8'd3);
    end_txn("data_nack", 3, 2, 1, 1, 0);
    wr_ptr = rd_ptr;

    // Address-only with a stray start mid-transfer; FIFO non-empty but must not be popped
    nack_plan = 8'h00;
    push(8'hEE);
    exp_bytes[0] = 8'hA0; exp_acks[0] = 0;
    begin_txn(7'h50, 8'd0);
    chk("len0_bytes_cleared", bytes_sent, 0);
    repeat (30) @(negedge clk);
    slave_addr = 7'h7F; len = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    end_txn("addr_only", 1, 0, 0, 0, 0);
    wr_ptr = rd_ptr;

    // Reset during data bit 4
    nack_plan = 8'h00;
    push(8'hA5); push(8'h3C);
    begin_txn(7'h50, 8'd2);
    hit = 1'b0;
    for (int i = 0; i < 4000 && !hit; i++) begin
      @(negedge clk);
      if (nbytes == 1 && bitcnt == 4 && scl_oe) hit = 1'b1;
    end
    chk("rst_mid_reached_bit4", hit, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_scl_oe", scl_oe, 0);
    chk("rst_mid_sda_oe", sda_oe, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_rd_en", fifo_rd_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_pops", pops - pops0, 1);
    chk("rst_mid_bytes_sent", bytes_sent, 0);
    wr_ptr = rd_ptr;
    repeat (3) @(negedge clk);

    // Normal transfer after the reset
    push(8'h5A); push(8'hC3);
    exp_bytes[0] = 8'h56; exp_bytes[1] = 8'h5A; exp_bytes[2] = 8'hC3;
    exp_acks[0] = 0; exp_acks[1] = 0; exp_acks[2] = 0;
    begin_txn(7'h2B, 8'd2);
    end_txn("after_reset", 3, 2, 2, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_fifo_tx_master.md
I2C_FIFO_TX_MASTER -- requirements
Module: i2c_fifo_tx_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 250, clk cycles per SCL quarter-period (100 MHz -> 100 kHz SCL); legal range 2..1023.
REQ-002 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  in  1  one-cycle transaction request; sampled only in IDLE.
REQ-005 SHALL have port slave_addr  in  7  target address, latched on accepted start.
REQ-006 SHALL have port len  in  8  data bytes to send, latched on accepted start; 0 = address-only.
REQ-007 SHALL have port fifo_rd_en  out  1  one-cycle pop request to the upstream sync FIFO.
REQ-008 SHALL have port fifo_data  in  8  FIFO read data, valid the cycle after fifo_rd_en.
REQ-009 SHALL have port fifo_empty  in  1  FIFO empty flag.
REQ-010 SHALL have port scl_oe  out  1  1 = drive SCL low, 0 = release (open-drain).
REQ-011 SHALL have port sda_oe  out  1  1 = drive SDA low, 0 = release.
REQ-012 SHALL have port sda_i  in  1  SDA line sample (ACK input); pre-synchronised externally.
REQ-013 SHALL have port busy  out  1  high from accepted start until return to IDLE.
REQ-014 SHALL have port done  out  1  one-cycle pulse when STOP completes.
REQ-015 SHALL have port nack_err  out  1  one-cycle pulse with done when a NACK ended the transfer.
REQ-016 SHALL have port underrun  out  1  one-cycle pulse with done when FIFO was empty before len bytes sent.
REQ-017 SHALL have port bytes_sent  out  8  count of data bytes ACKed in current/last transfer.

Function
REQ-018 Quarter counter SHALL count 0..CLK_DIV-1 then advance phase q0..q3; counter held at 0 in IDLE.
REQ-019 States SHALL be IDLE, START, ADDR, ADDR_ACK, FETCH, WAIT_DATA, DATA, DATA_ACK, STOP.
REQ-020 IDLE: scl_oe=0, sda_oe=0; start=1 -> latch inputs, clear bytes_sent, busy=1, go START.
REQ-021 START (4 quarters): q0-q1 SCL/SDA released; q2-q3 sda_oe=1 (SDA falls while SCL high); then ADDR.
REQ-022 Each bit SHALL occupy 4 quarters: q0-q1 scl_oe=1, SDA updated at q0 entry; q2-q3 scl_oe=0; SDA stable q1-q3.
REQ-023 ADDR SHALL send {slave_addr, 1'b0} MSB first (8 bits); sda_oe = ~bit.
REQ-024 ADDR_ACK/DATA_ACK: sda_oe=0 for the 9th bit; sda_i sampled on first clk of q3; 0=ACK, 1=NACK.
REQ-025 Address NACK -> STOP with nack_err pending; ACK -> FETCH if len!=0, else STOP.
REQ-026 FETCH (SCL held low, sda_oe held): if fifo_empty=0 assert fifo_rd_en one cycle, go WAIT_DATA; if fifo_empty=1 -> STOP with underrun pending.
REQ-027 WAIT_DATA SHALL capture fifo_data into shift register the cycle after fifo_rd_en, then DATA; fifo_rd_en SHALL never be asserted while fifo_empty=1 nor twice per byte.
REQ-028 DATA SHALL send 8 bits MSB first; DATA_ACK ACK -> bytes_sent+1; then FETCH if bytes_sent+1 < len, else STOP.
REQ-029 Data NACK SHALL go to STOP with nack_err pending; NACKed byte not counted.
REQ-030 STOP (4 quarters): q0 scl_oe=1, sda_oe=1; q1-q2 scl_oe=0, sda_oe=1; q3 sda_oe=0 (SDA rises while SCL high); then done pulse, IDLE.
REQ-031 nack_err and underrun SHALL be mutually exclusive; pulse only coincident with done.
REQ-032 start while busy SHALL be ignored; latched slave_addr/len unaffected.
REQ-033 SCL SHALL be held low (scl_oe=1) throughout FETCH/WAIT_DATA; no SCL edge until data captured.
REQ-034 bytes_sent SHALL be 8-bit, no wrap (max len=255), held after done until next accepted start.

Reset
REQ-035 rst_n=0 at any clk edge SHALL force IDLE, counters 0, scl_oe=0, sda_oe=0, fifo_rd_en=0, busy=0, done=0, nack_err=0, underrun=0, bytes_sent=0, shift register 0.
REQ-036 Reset mid-transfer SHALL release both lines on the next edge; no STOP generated; no FIFO pop issued.

Verification
REQ-037 CLK_DIV=4, addr=0x50, len=2, FIFO holds 0xA5,0x3C, slave ACKs all -> SDA bits 0xA0,ACK,0xA5,ACK,0x3C,ACK; exactly 2 fifo_rd_en; done, bytes_sent=2, no errors.
REQ-038 addr=0x21, len=3, slave NACKs address -> no fifo_rd_en, STOP, done+nack_err, bytes_sent=0.
REQ-039 len=4, FIFO holds 2 bytes, all ACK -> 2 bytes sent, FIFO empty at 3rd FETCH -> STOP, done+underrun, bytes_sent=2.
REQ-040 len=3, slave NACKs 2nd data byte -> STOP after byte 2, done+nack_err, bytes_sent=1, 2 pops.
REQ-041 len=0 -> address 0xA0 only, ACK, STOP, done, zero pops; start pulsed mid-transfer ignored.
REQ-042 rst_n=0 during DATA bit 4 -> next edge scl_oe=0, sda_oe=0, busy=0; new start afterwards completes normally.
